alu_exec_stage: RTL and testbench

- Registered execute stage directly downstream of the ALU control decoder.
- Consumes the 3-bit ALU control code plus two operands, computes result and flags, and holds them in an output register.
- Uses a valid/ready handshake and a one-entry skid buffer, so downstream stalls (memory/writeback) never drop an accepted operation.
- Sustains one operation per cycle when unstalled.

---
 rtl/alu_exec_stage_pkg.sv | 11 +
 rtl/alu_exec_stage_if.sv | 32 +++
 rtl/alu_exec_stage_alu_core.sv | 44 ++++
 rtl/alu_exec_stage.sv | 86 ++++++++
 tb/tb_alu_exec_stage.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU op encodings and default datapath widths for the decoder and execute stage.
package alu_exec_stage_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_RD_W  = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
endpackage

// File: rtl/alu_exec_stage_if.sv
// Execute-stage bus: upstream valid/ready operation, downstream valid/ready result, and flush.
interface alu_exec_stage_if
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RD_W  = DEF_RD_W
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [RD_W-1:0]  rd_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal_op;
  logic [RD_W-1:0]  rd_out;

  modport master (
    output flush, in_valid, alu_control, src_a, src_b, rd_in, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal_op, rd_out
  );

  modport slave (
    input  flush, in_valid, alu_control, src_a, src_b, rd_in, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal_op, rd_out
  );
endinterface

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational ALU: result plus zero/overflow/illegal flags from op code and operands.
module alu_core
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       alu_control_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             illegal_op_o
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = src_a_i + src_b_i;
  assign diff = src_a_i - src_b_i;

  always_comb begin
    result_o     = '0;
    overflow_o   = 1'b0;
    illegal_op_o = 1'b0;
    case (alu_control_i)
      ALU_ADD: begin
        result_o   = sum;
        overflow_o = (src_a_i[MSB] == src_b_i[MSB]) && (sum[MSB] != src_a_i[MSB]);
      end
      ALU_SUB: begin
        result_o   = diff;
        overflow_o = (src_a_i[MSB] != src_b_i[MSB]) && (diff[MSB] != src_a_i[MSB]);
      end
      ALU_AND: result_o = src_a_i & src_b_i;
      ALU_OR:  result_o = src_a_i | src_b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(src_a_i) < $signed(src_b_i))};
      default: illegal_op_o = 1'b1;
    endcase
  end

  assign zero_o = (result_o == '0);
endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: output register O plus one-entry skid S, 1-cycle latency.
// in_ready is a flop (!sv), so a downstream stall never reaches upstream combinationally.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RD_W  = DEF_RD_W
) (
  input  logic            clk,
  input  logic            rst,
  alu_exec_stage_if.slave bus
);
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal_op;
    logic [RD_W-1:0]  rd;
  } entry_t;

  entry_t new_ent;
  entry_t o_q, o_d, s_q, s_d;
  logic   ov_q, ov_d, sv_q, sv_d;
  logic   rdy_q;
  logic   accept, drain;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_control_i (bus.alu_control),
    .src_a_i       (bus.src_a),
    .src_b_i       (bus.src_b),
    .result_o      (new_ent.result),
    .zero_o        (new_ent.zero),
    .overflow_o    (new_ent.overflow),
    .illegal_op_o  (new_ent.illegal_op)
  );
  assign new_ent.rd = bus.rd_in;

  assign accept = bus.in_valid & rdy_q;
  assign drain  = ov_q & bus.out_ready;

  always_comb begin
    o_d  = o_q;
    s_d  = s_q;
    ov_d = ov_q;
    sv_d = sv_q;
    if (bus.flush) begin
      ov_d = 1'b0;
      sv_d = 1'b0;
    end else if (drain && sv_q) begin
      o_d  = s_q;
      sv_d = 1'b0;
    end else if (accept && (!ov_q || drain)) begin
      o_d  = new_ent;
      ov_d = 1'b1;
    end else if (accept) begin
      s_d  = new_ent;
      sv_d = 1'b1;
    end else if (drain) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q   <= '0;
      s_q   <= '0;
      ov_q  <= 1'b0;
      sv_q  <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      o_q   <= o_d;
      s_q   <= s_d;
      ov_q  <= ov_d;
      sv_q  <= sv_d;
      rdy_q <= !sv_d;
    end
  end

  assign bus.in_ready   = rdy_q;
  assign bus.out_valid  = ov_q;
  assign bus.result     = o_q.result;
  assign bus.zero       = o_q.zero;
  assign bus.overflow   = o_q.overflow;
  assign bus.illegal_op = o_q.illegal_op;
  assign bus.rd_out     = o_q.rd;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed corner cases then random traffic against a queue model.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ovf;
    logic        ill;
    logic [4:0]  rd;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   errs    = 0;
  exp_t q[$];

  alu_exec_stage_if bus ();

  alu_exec_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_alu(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] rd);
    exp_t   e;
    longint sa, sb, full;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e.res = 32'd0;
    e.ovf = 1'b0;
    e.ill = 1'b0;
    e.rd  = rd;
    case (op)
      3'd0: begin full = sa + sb; e.res = full[31:0]; e.ovf = (full > SMAX) || (full < SMIN); end
      3'd1: begin full = sa - sb; e.res = full[31:0]; e.ovf = (full > SMAX) || (full < SMIN); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check_outputs();
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0) begin
      chk("result", bus.result, q[0].res);
      chk("zero", {31'd0, bus.zero}, {31'd0, q[0].z});
      chk("overflow", {31'd0, bus.overflow}, {31'd0, q[0].ovf});
      chk("illegal_op", {31'd0, bus.illegal_op}, {31'd0, q[0].ill});
      chk("rd_out", {27'd0, bus.rd_out}, {27'd0, q[0].rd});
    end
  endtask

  // Drive at a negedge, let one rising edge happen, update the model, check at the next negedge.
  task automatic cycle(input logic vld, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic ordy, input logic fl);
    bit pop, push;
    bus.in_valid    = vld;
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.rd_in       = rd;
    bus.out_ready   = ordy;
    bus.flush       = fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      pop  = (q.size() > 0) && ordy;
      push = vld && (q.size() < 2);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ref_alu(op, a, b, rd));
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.alu_control = 3'd0;
    bus.src_a       = 32'd0;
    bus.src_b       = 32'd0;
    bus.rd_in       = 5'd0;
    bus.out_ready   = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_flags", {29'd0, bus.zero, bus.overflow, bus.illegal_op}, 32'd0);
    chk("rst_rd_out", {27'd0, bus.rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    cycle(1, ALU_ADD, 32'd5, 32'd7, 5'd3, 1, 0);
    chk("add_result", bus.result, 32'd12);
    chk("add_rd", {27'd0, bus.rd_out}, 32'd3);
    chk("add_zero", {31'd0, bus.zero}, 32'd0);

    cycle(1, ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1, 0);
    chk("sub_ovf_result", bus.result, 32'h8000_0000);
    chk("sub_ovf_flag", {31'd0, bus.overflow}, 32'd1);
    cycle(1, ALU_SUB, 32'd9, 32'd9, 5'd5, 1, 0);
    chk("sub_zero", {31'd0, bus.zero}, 32'd1);
    cycle(1, ALU_SLT, 32'hFFFF_FFFE, 32'd1, 5'd6, 1, 0);
    chk("slt_neg", bus.result, 32'd1);
    cycle(1, ALU_SLT, 32'd1, 32'hFFFF_FFFE, 5'd7, 1, 0);
    chk("slt_pos", bus.result, 32'd0);
    cycle(1, 3'b110, 32'd3, 32'd4, 5'd8, 1, 0);
    chk("illegal_flag", {31'd0, bus.illegal_op}, 32'd1);
    chk("illegal_zero", {31'd0, bus.zero}, 32'd1);

    cycle(0, ALU_ADD, 32'd0, 32'd0, 5'd0, 1, 0);
    cycle(1, ALU_ADD, 32'd1, 32'd1, 5'd10, 0, 0);
    chk("b2b_a_held", {27'd0, bus.rd_out}, 32'd10);
    cycle(1, ALU_ADD, 32'd2, 32'd2, 5'd11, 0, 0);
    chk("b2b_full_rdy", {31'd0, bus.in_ready}, 32'd0);
    cycle(1, ALU_ADD, 32'd3, 32'd3, 5'd12, 0, 0);
    chk("b2b_c_stalled", {27'd0, bus.rd_out}, 32'd10);
    cycle(1, ALU_ADD, 32'd3, 32'd3, 5'd12, 1, 0);
    chk("b2b_b_out", {27'd0, bus.rd_out}, 32'd11);
    cycle(1, ALU_ADD, 32'd3, 32'd3, 5'd12, 1, 0);
    chk("b2b_c_out", {27'd0, bus.rd_out}, 32'd12);
    chk("b2b_c_result", bus.result, 32'd6);
    cycle(0, ALU_ADD, 32'd0, 32'd0, 5'd0, 1, 0);
    chk("b2b_empty", {31'd0, bus.out_valid}, 32'd0);

    cycle(1, ALU_ADD, 32'd4, 32'd4, 5'd20, 0, 0);
    cycle(1, ALU_ADD, 32'd5, 32'd5, 5'd21, 0, 0);
    cycle(1, ALU_OR, 32'd6, 32'd6, 5'd22, 0, 1);
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);
    cycle(0, ALU_ADD, 32'd0, 32'd0, 5'd0, 1, 0);
    chk("flush_nothing", {31'd0, bus.out_valid}, 32'd0);

    cycle(1, ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd23, 0, 0);
    cycle(1, ALU_ADD, 32'd8, 32'd8, 5'd24, 0, 0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("arst_result", bus.result, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
            5'($urandom), ($urandom_range(0, 4) < 3), ($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
